// File: rtl/gcd_pkg.sv
// gcd_pkg: shared state encoding and default sizing for the GCD arbiter slice
package gcd_pkg;
  typedef enum logic [1:0] {IDLE, ABS, RUN, DONE} state_e;
  localparam int DEF_N_REQ    = 2;
  localparam int DEF_WIDTH    = 8;
  localparam int DEF_MAX_ITER = 255;
endpackage

// File: rtl/gcd_arbiter_if.sv
// gcd_arbiter_if: requester-side operand/request bus and tagged result bus
interface gcd_arbiter_if #(
  parameter int N_REQ = 2,
  parameter int WIDTH = 8
) ();
  logic [N_REQ-1:0]       req, gnt;
  logic [N_REQ*WIDTH-1:0] a_in, b_in;
  logic                   busy, res_valid, res_err;
  logic [2:0]             res_id;
  logic [WIDTH-1:0]       result;
  modport master (output req, a_in, b_in, input gnt, busy, res_valid, res_id, result, res_err);
  modport slave  (input req, a_in, b_in, output gnt, busy, res_valid, res_id, result, res_err);
endinterface

// File: rtl/gcd_core.sv
// gcd_core: subtract-based GCD engine with magnitude stage and iteration timeout
module gcd_core import gcd_pkg::*; #(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int MAX_ITER = DEF_MAX_ITER
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             err_o,
  output logic [WIDTH-1:0] result_o
);
  localparam int CW = $clog2(MAX_ITER + 2);
  state_e           state_q;
  logic [WIDTH-1:0] x_q, y_q, res_q, x_d, y_d, res_d;
  logic [CW-1:0]    cnt_q;
  logic             done_q, err_q, fin, tmo, zz;
  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v);
    return v[WIDTH-1] ? -v : v;
  endfunction
  always_comb begin
    zz    = x_q == '0 && y_q == '0;
    fin   = x_q == '0 || y_q == '0 || x_q == y_q;
    tmo   = cnt_q == CW'(MAX_ITER + 1);
    res_d = fin ? (x_q == '0 ? y_q : x_q) : '0;
    x_d   = x_q > y_q ? x_q - y_q : x_q;
    y_d   = x_q > y_q ? y_q : y_q - x_q;
  end
  // operands are latched raw on start and folded to magnitudes in ABS
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      x_q     <= '0;
      y_q     <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (start_i) begin
          x_q     <= a_i;
          y_q     <= b_i;
          state_q <= ABS;
        end
        ABS: begin
          x_q     <= mag(x_q);
          y_q     <= mag(y_q);
          cnt_q   <= '0;
          state_q <= RUN;
        end
        RUN: if (fin || tmo) begin
          res_q   <= res_d;
          err_q   <= zz || !fin;
          done_q  <= 1'b1;
          state_q <= DONE;
        end else begin
          x_q   <= x_d;
          y_q   <= y_d;
          cnt_q <= cnt_q + 1'b1;
        end
        DONE: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end
  assign busy_o   = state_q != IDLE;
  assign done_o   = done_q;
  assign err_o    = err_q;
  assign result_o = res_q;
endmodule

// File: rtl/gcd_arbiter.sv
// gcd_arbiter: round-robin sharing of one GCD engine among N_REQ requesters,
// results tagged with the owning requester id
module gcd_arbiter import gcd_pkg::*; #(
  parameter int N_REQ    = DEF_N_REQ,
  parameter int WIDTH    = DEF_WIDTH,
  parameter int MAX_ITER = DEF_MAX_ITER
) (
  input logic          CLOCK_50,
  input logic          RESET_N,
  gcd_arbiter_if.slave bus
);
  logic [N_REQ-1:0] gnt_q;
  logic [2:0]       ptr_q, id_q, sel;
  logic             hit, start, busy;
  // scan downward so the lowest offset from the pointer wins
  always_comb begin
    sel = '0;
    hit = 1'b0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (bus.req[(int'(ptr_q) + i) % N_REQ]) begin
        sel = 3'((int'(ptr_q) + i) % N_REQ);
        hit = 1'b1;
      end
    end
  end
  assign start = hit && !busy;
  always_ff @(posedge CLOCK_50) begin
    if (!RESET_N) begin
      gnt_q <= '0;
      ptr_q <= '0;
      id_q  <= '0;
    end else begin
      gnt_q <= start ? N_REQ'(1) << sel : '0;
      if (start) begin
        id_q  <= sel;
        ptr_q <= int'(sel) == N_REQ - 1 ? '0 : sel + 3'd1;
      end
    end
  end
  gcd_core #(.WIDTH(WIDTH), .MAX_ITER(MAX_ITER)) u_core (
    .clk      (CLOCK_50),
    .rst_n    (RESET_N),
    .start_i  (start),
    .a_i      (bus.a_in[sel*WIDTH +: WIDTH]),
    .b_i      (bus.b_in[sel*WIDTH +: WIDTH]),
    .busy_o   (busy),
    .done_o   (bus.res_valid),
    .err_o    (bus.res_err),
    .result_o (bus.result)
  );
  assign bus.gnt    = gnt_q;
  assign bus.res_id = id_q;
  assign bus.busy   = busy;
endmodule
